// File: rtl/grid_frame_scanner.sv
// grid_frame_scanner
//   Scans a GRID_W x GRID_H cell grid in row-major order. For each cell it
//   drives x_out/y_out into the game core and waits SETTLE_CYC cycles for the
//   core's flags to settle. It then samples the flags and encodes one RGB565
//   word, which it offers to the display driver. One frame is produced per
//   accepted frame_start pulse.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   frame_start     1-cycle request to scan a frame (accepted only in IDLE)
//   x_out, y_out    cell coordinates presented to the game core
//   apple_in, wall_in, body_in, head_in, gameover_in
//                   game core flags for the presented cell
//   pix_data        RGB565 word for the current cell
//   pix_valid       pix_data is offered to the display driver
//   pix_ready       display driver can take the offered word
//   pix_last        marks the final cell of the frame (qualified by pix_valid)
//   busy            a frame scan is in progress
//   frame_done      1-cycle pulse after the final word is accepted
//   state_dbg       current FSM state (0 IDLE, 1 SETTLE, 2 SAMPLE, 3 SEND)
//
// Handshake: a word transfers on a rising edge where pix_valid && pix_ready.
//   Once pix_valid is raised, pix_data, pix_last, x_out and y_out stay frozen
//   until that transfer. pix_valid never drops without a transfer, except
//   when rst aborts the frame.
module grid_frame_scanner #(
  parameter int GRID_W     = 16,
  parameter int GRID_H     = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  output logic [3:0]  x_out,
  output logic [3:0]  y_out,
  input  logic        apple_in,
  input  logic        wall_in,
  input  logic        body_in,
  input  logic        head_in,
  input  logic        gameover_in,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last,
  output logic        busy,
  output logic        frame_done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_SEND   = 2'd3
  } state_t;

  localparam logic [3:0] X_MAX       = 4'(GRID_W - 1);
  localparam logic [3:0] Y_MAX       = 4'(GRID_H - 1);
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC - 1);

  localparam logic [15:0] COL_GAMEOVER = 16'hF800;
  localparam logic [15:0] COL_HEAD     = 16'hFFE0;
  localparam logic [15:0] COL_BODY     = 16'h07E0;
  localparam logic [15:0] COL_APPLE    = 16'hF81F;
  localparam logic [15:0] COL_WALL     = 16'h7BEF;
  localparam logic [15:0] COL_NONE     = 16'h0000;

  state_t      state;
  logic [3:0]  settle_cnt;
  logic        last_cell;
  logic [15:0] enc;

  assign last_cell = (x_out == X_MAX) && (y_out == Y_MAX);
  assign state_dbg = state;

  // Colour priority: a game-over overrides everything, and the head is drawn
  // on top of any other object that shares its cell.
  always_comb begin
    enc = COL_NONE;
    if (gameover_in)   enc = COL_GAMEOVER;
    else if (head_in)  enc = COL_HEAD;
    else if (body_in)  enc = COL_BODY;
    else if (apple_in) enc = COL_APPLE;
    else if (wall_in)  enc = COL_WALL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= 4'd0;
      x_out      <= 4'd0;
      y_out      <= 4'd0;
      pix_data   <= 16'h0000;
      pix_valid  <= 1'b0;
      pix_last   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // A start that coincides with the frame_done pulse belongs to the
          // frame that just finished and is dropped.
          if (frame_start && !frame_done) begin
            state      <= S_SETTLE;
            x_out      <= 4'd0;
            y_out      <= 4'd0;
            busy       <= 1'b1;
            settle_cnt <= SETTLE_INIT;
          end
        end

        S_SETTLE: begin
          if (settle_cnt == 4'd0) state <= S_SAMPLE;
          else                    settle_cnt <= settle_cnt - 4'd1;
        end

        S_SAMPLE: begin
          pix_data  <= enc;
          pix_valid <= 1'b1;
          pix_last  <= last_cell;
          state     <= S_SEND;
        end

        S_SEND: begin
          if (pix_valid && pix_ready) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            if (last_cell) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              x_out      <= 4'd0;
              y_out      <= 4'd0;
            end else begin
              state      <= S_SETTLE;
              settle_cnt <= SETTLE_INIT;
              if (x_out == X_MAX) begin
                x_out <= 4'd0;
                y_out <= y_out + 4'd1;
              end else begin
                x_out <= x_out + 4'd1;
              end
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_frame_scanner.sv
// Bench for grid_frame_scanner: a small game-core model answers coordinate
// queries, expected words are queued when a frame is requested, and a
// monitor pops and compares them on every accepted word.
module tb_grid_frame_scanner;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        frame_start;
  logic [3:0]  x_out, y_out;
  logic        apple_in, wall_in, body_in, head_in, gameover_in;
  logic [15:0] pix_data;
  logic        pix_valid, pix_ready, pix_last, busy, frame_done;
  logic [1:0]  state_dbg;

  grid_frame_scanner #(.GRID_W(16), .GRID_H(16), .SETTLE_CYC(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .x_out       (x_out),
    .y_out       (y_out),
    .apple_in    (apple_in),
    .wall_in     (wall_in),
    .body_in     (body_in),
    .head_in     (head_in),
    .gameover_in (gameover_in),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_last    (pix_last),
    .busy        (busy),
    .frame_done  (frame_done),
    .state_dbg   (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Encoder vectors: flags {gameover, head, body, apple, wall} and the
  // colour they must produce. Vector i is placed on cell index i of a frame.
  typedef struct {
    logic [4:0]  flags;
    logic [15:0] exp;
  } vec_t;
  localparam int NV = 12;
  vec_t tbl[NV];

  // ---------------- game core model ----------------
  // mode 0: empty grid, 1: scene, 2: scene + gameover, 3: encoder vectors
  int mode      = 0;
  int ready_pct = 100;

  always_comb begin
    gameover_in = 1'b0;
    head_in     = 1'b0;
    body_in     = 1'b0;
    apple_in    = 1'b0;
    wall_in     = 1'b0;
    if (mode == 1 || mode == 2) begin
      head_in     = (x_out == 4'd3) && (y_out == 4'd4);
      body_in     = (x_out == 4'd2) && (y_out == 4'd4);
      apple_in    = (x_out == 4'd7) && (y_out == 4'd9);
      wall_in     = (x_out == 4'd0);
      gameover_in = (mode == 2);
    end else if (mode == 3) begin
      if ({y_out, x_out} < 8'(NV))
        {gameover_in, head_in, body_in, apple_in, wall_in} = tbl[{y_out, x_out}].flags;
    end
  end

  function automatic logic [15:0] exp_pix(input int m, input int x, input int y);
    if (m == 2) return 16'hF800;
    if (m == 3) return (y * 16 + x < NV) ? tbl[y * 16 + x].exp : 16'h0000;
    if (m == 1) begin
      if (x == 3 && y == 4) return 16'hFFE0;
      if (x == 2 && y == 4) return 16'h07E0;
      if (x == 7 && y == 9) return 16'hF81F;
      if (x == 0)           return 16'h7BEF;
    end
    return 16'h0000;
  endfunction

  // ---------------- ready driver ----------------
  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 pix_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  // Expected entry layout: {x[3:0], y[3:0], last, data[15:0]}
  logic [24:0] exp_q[$];
  int          accept_cnt = 0;
  int          done_cnt   = 0;
  logic        prev_stall = 1'b0;
  logic        prev_last_acc = 1'b0;
  logic [24:0] prev_snap;
  logic [24:0] e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall    = 1'b0;
      prev_last_acc = 1'b0;
    end else begin
      check("frame_done_timing", frame_done, prev_last_acc);
      if (frame_done) done_cnt++;
      if (prev_stall)
        check("stall_hold", {pix_valid, x_out, y_out, pix_last, pix_data}, {1'b1, prev_snap});
      prev_last_acc = 1'b0;
      if (pix_valid && pix_ready) begin
        accept_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=0x%0h expected=none", {x_out, y_out, pix_last, pix_data});
        end else begin
          e = exp_q.pop_front();
          check("word_xy_last_data", {x_out, y_out, pix_last, pix_data}, e);
        end
        prev_last_acc = pix_last;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_snap  = {x_out, y_out, pix_last, pix_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_outputs_zero(input string tag);
    check({tag, "_x"},          x_out,      0);
    check({tag, "_y"},          y_out,      0);
    check({tag, "_data"},       pix_data,   0);
    check({tag, "_valid"},      pix_valid,  0);
    check({tag, "_last"},       pix_last,   0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_state"},      state_dbg,  0);
  endtask

  task automatic push_frame(input int m);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        exp_q.push_back({4'(x), 4'(y), (x == 15 && y == 15), exp_pix(m, x, y)});
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_accepts(input int base, input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (accept_cnt - base >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_frame(input int m, input int pct, input string tag);
    int base;
    bit ok;
    mode      = m;
    ready_pct = pct;
    push_frame(m);
    base = accept_cnt;
    pulse_start();
    check({tag, "_busy_start"},  busy,      1);
    check({tag, "_state_start"}, state_dbg, 1);
    wait_done(ok);
    check({tag, "_frame_done_seen"}, ok, 1);
    check({tag, "_accepts"},         accept_cnt - base, 256);
    check({tag, "_queue_drained"},   exp_q.size(), 0);
    check({tag, "_busy_end"},        busy, 0);
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int  base;
    int  done_base;
    bit  ok;

    tbl[0]  = '{5'b00000, 16'h0000};
    tbl[1]  = '{5'b00001, 16'h7BEF};
    tbl[2]  = '{5'b00010, 16'hF81F};
    tbl[3]  = '{5'b00011, 16'hF81F};
    tbl[4]  = '{5'b00100, 16'h07E0};
    tbl[5]  = '{5'b00111, 16'h07E0};
    tbl[6]  = '{5'b01000, 16'hFFE0};
    tbl[7]  = '{5'b01001, 16'hFFE0};
    tbl[8]  = '{5'b01111, 16'hFFE0};
    tbl[9]  = '{5'b10000, 16'hF800};
    tbl[10] = '{5'b11111, 16'hF800};
    tbl[11] = '{5'b10001, 16'hF800};

    rst         = 1'b1;
    frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("idle");

    // Blank frame, then the scene, encoder vectors, game-over frame.
    run_frame(0, 100, "blank");
    run_frame(1, 100, "scene");
    run_frame(3, 100, "vectors");
    run_frame(2, 100, "gameover");

    // Scene again with a stalling display driver.
    run_frame(1, 30, "stall");

    // Starts mid-frame and in the frame_done cycle are dropped.
    mode      = 0;
    ready_pct = 100;
    push_frame(0);
    base = accept_cnt;
    pulse_start();
    wait_accepts(base, 40, ok);
    check("busy_start_reached_40", ok, 1);
    pulse_start();
    check("busy_after_mid_start", busy, 1);
    wait_done(ok);
    check("busy_start_frame_done_seen", ok, 1);
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    check("done_cycle_start_busy",  busy,      0);
    check("done_cycle_start_state", state_dbg, 0);
    repeat (20) @(negedge clk);
    check("done_cycle_start_valid", pix_valid, 0);
    check("busy_start_accepts",     accept_cnt - base, 256);
    check("busy_start_queue",       exp_q.size(), 0);
    exp_q.delete();

    // Reset mid-frame aborts immediately with no frame_done.
    mode = 1;
    push_frame(1);
    base = accept_cnt;
    pulse_start();
    wait_accepts(base, 100, ok);
    check("abort_reached_100", ok, 1);
    check("abort_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1 check_outputs_zero("abort");
    exp_q.delete();
    done_base = done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_frame_done", done_cnt - done_base, 0);
    check_outputs_zero("after_abort");

    // Scanner still works after the abort.
    run_frame(3, 100, "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
